// File: rtl/jedro_1_defines.sv
// Shared types and defaults for the jedro_1 prefetching instruction fetch unit.
// No logic: enum and parameter defaults only.
// Used by the IFU top and anything that needs its state encoding.
package jedro_1_defines;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } ifu_state_t;

    localparam int          IFU_FIFO_DEPTH = 4;
    localparam logic [31:0] BOOT_ADDR      = 32'h0000_0000;

endpackage

// File: rtl/jedro_1_sync_fifo.sv
// Synchronous FIFO with flush; pop-side data is the registered head entry.
// Latency: a push is visible at dout/empty the cycle after it is written.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; flush beats push.
module jedro_1_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import jedro_1_defines::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy; a full FIFO may still accept a push alongside a pop.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jedro_1_prefetch_ifu.sv
// Prefetching instruction fetch unit: streams sequential words from instruction RAM into a small FIFO.
// Latency: RAM latency + 1 cycle from response to instr_valid_o (no bypass); first request one cycle after reset.
// Backpressure: requests are credit-limited so FIFO entries plus in-flight reads never exceed FIFO_DEPTH.
module jedro_1_prefetch_ifu #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = jedro_1_defines::IFU_FIFO_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = ADDR_WIDTH'(jedro_1_defines::BOOT_ADDR)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    output logic                  ram_req_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    input  logic                  ram_rvalid_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    input  logic                  jmp_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
    output logic                  jmp_misaligned_o
);
    import jedro_1_defines::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = DATA_WIDTH + ADDR_WIDTH;

    ifu_state_t            state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop_cnt;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           in_use;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FW-1:0]         fifo_dout;
    logic                  jmp_take;
    logic                  jmp_bad;
    logic                  credit_ok;
    logic                  resp_accept;
    logic                  pop;

    // A misaligned redirect is reported and otherwise treated as if jmp_i were low.
    assign jmp_bad   = jmp_i && (jmp_addr_i[1:0] != 2'b00);
    assign jmp_take  = jmp_i && (jmp_addr_i[1:0] == 2'b00);

    // Entries held plus reads in flight (stale ones included) must stay below the FIFO size.
    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding};
    assign credit_ok = (in_use < (CW+1)'(FIFO_DEPTH));

    assign ram_req_o  = (state == RUN) && !jmp_take && credit_ok;
    assign ram_addr_o = fetch_pc;

    assign pop         = instr_valid_o && instr_ready_i;
    assign resp_accept = ram_rvalid_i && (drop_cnt == '0) && !jmp_take && (!fifo_full || pop);

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_dout[FW-1:ADDR_WIDTH];
    assign instr_pc_o    = fifo_dout[ADDR_WIDTH-1:0];

    // Boot/run sequencing, fetch and response PC tracking, misalignment pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state            <= BOOT;
            fetch_pc         <= BOOT_ADDR;
            resp_pc          <= BOOT_ADDR;
            jmp_misaligned_o <= 1'b0;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                default: state <= RUN;
            endcase
            jmp_misaligned_o <= jmp_bad;
            if (jmp_take) begin
                fetch_pc <= jmp_addr_i;
            end else if (ram_req_o) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
            // Responses return in order, so the next kept response is always resp_pc.
            if (jmp_take) begin
                resp_pc <= jmp_addr_i;
            end else if (resp_accept) begin
                resp_pc <= resp_pc + ADDR_WIDTH'(4);
            end
        end
    end

    // In-flight read count and the number of stale responses still to be discarded.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            case ({ram_req_o, ram_rvalid_i})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            if (jmp_take) begin
                drop_cnt <= ram_rvalid_i ? (outstanding - CW'(1)) : outstanding;
            end else if (ram_rvalid_i && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    jedro_1_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (resp_accept),
        .din    ({ram_rdata_i, resp_pc}),
        .pop    (pop),
        .flush  (jmp_take),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule
